adc_acq_sequencer: RTL and testbench
====================================

Name: adc_acq_sequencer

Overview:
Sequences one AD7643 pair (ch0/ch1) in serial-slave readout. Each sample point is one common conversion on both ADCs, followed by an 18-bit serial shift from both SDOUT lines. The shared waveform-memory write port is then arbitrated between the two channels, ch0 first. Sits between the USB command decoder (START/STOP/NSAMPLES) and the waveform memory that the USB transmit path drains.

Parameters:
CONV_PERIOD, 250, clocks from one CNVST rise to the next; minimum period, stretched if the sequence is longer.
CNVST_W, 4, CNVST high width in clocks.
BUSY_TMO, 200, max clocks from CNVST rise to BUSY fall.
NBITS, 18, ADC word length.
OUT_W, 16, memory data width; stored word is sample[NBITS-1:NBITS-OUT_W].
ADRS_W, 15, memory address width.

Ports:
CLK  in  1  system clock; all logic on negedge CLK.
RSTN  in  1  asynchronous active-low reset.
START  in  1  one-clock pulse; begin acquisition at address 0.
STOP  in  1  one-clock pulse; finish the current sample, then idle.
NSAMPLES  in  ADRS_W  sample points to take; 0 = continuous with wrap.
CH_EN  in  2  channel enables, latched at START.
ADCNVST  out  1  convert start, shared by both ADCs.
ADCS  out  1  chip select, active low, shared.
ADSCLK  out  1  serial clock, shared.
ADSDOUT0, ADSDOUT1  in  1  serial data.
ADBUSY0, ADBUSY1  in  1  conversion busy.
MEM_WE  out  1  memory write strobe, one clock.
MEM_ADRS  out  ADRS_W  write address.
MEM_DATA  out  OUT_W  write data.
ACTIVE  out  1  high while not IDLE.
DONE  out  1  one-clock pulse when acquisition ends normally.
ERR  out  1  sticky BUSY timeout; cleared by START.
SAMPLE_CNT  out  ADRS_W  completed sample points.

Behaviour:
- Reset values: ADCNVST=0, ADCS=1, ADSCLK=0, MEM_WE=0, MEM_ADRS=0, MEM_DATA=0, ACTIVE=0, DONE=0, ERR=0, SAMPLE_CNT=0; state IDLE; period counter 0.
- IDLE: START with CH_EN!=0 latches CH_EN and NSAMPLES, clears ERR, SAMPLE_CNT and address, then enters CONV. START with CH_EN==0 is ignored. START while not IDLE is ignored.
- CONV: ADCNVST=1 for CNVST_W clocks. The period counter restarts at 0 on entry. Next state is WAITBUSY.
- WAITBUSY: waits until every enabled BUSY has been seen high and is now low. If the period counter reaches BUSY_TMO first: set ERR, go to IDLE, no DONE pulse, no write.
- SHIFT: ADCS=0. ADSCLK toggles every clock. On each ADSCLK 1->0 transition, shift both SDOUTs MSB-first into 18-bit shift registers. After NBITS falling transitions: ADSCLK=0, ADCS=1, go to WR0.
- WR0: if ch0 enabled, MEM_WE=1 for one clock with ch0 data, then address+1. Go to WR1.
- WR1: same for ch1. With both channels enabled, ch0 lands at even and ch1 at odd addresses (interleaved).
- After WR1: SAMPLE_CNT+1, then go to HOLD.
- HOLD: wait until the period counter reaches CONV_PERIOD-1, then choose the next state.
  - Pending STOP, or SAMPLE_CNT==NSAMPLES (NSAMPLES!=0): go to IDLE and pulse DONE.
  - Otherwise: go to CONV.
- Overrun: if the counter already exceeds CONV_PERIOD-1, go to CONV immediately. Conversions never overlap.
- STOP pulse in any non-IDLE state is latched and honoured only at HOLD exit. The current sample is always written. STOP in IDLE is ignored.
- Simultaneous START and STOP in IDLE: START wins, STOP is discarded.
- Address wraps 2^ADRS_W-1 -> 0 silently. SAMPLE_CNT wraps the same way in continuous mode.
- RSTN low mid-operation: immediate return to reset values. No partial write is issued.

Decomposition:
- Shared package: state encoding (IDLE, CONV, WAITBUSY, SHIFT, WR0, WR1, HOLD) and default parameter constants (CONV_PERIOD, NBITS, ADRS_W), reused by the USB command decoder.
- One natural sub-module: adc_serial_shifter. It generates ADSCLK, counts NBITS and holds both shift registers. Interface is start/done plus the two data words.

Test Plan:
- Single channel: CH_EN=01, NSAMPLES=3, ADC model returns 0x2AAAA.
  -> 3 writes of 0xAAAA at adrs 0,1,2; CNVST rises 250 clocks apart; DONE pulse; SAMPLE_CNT=3.
- Dual channel: CH_EN=11, NSAMPLES=2, ch0=0x3FFFF, ch1=0x00004.
  -> writes 0xFFFF@0, 0x0001@1, 0xFFFF@2, 0x0001@3.
- BUSY stuck high: ch0 BUSY never falls.
  -> ERR=1 at CNVST+200 clocks, IDLE, no MEM_WE, no DONE; next START clears ERR.
- STOP mid-shift in continuous mode.
  -> current sample written, HOLD completes, IDLE with DONE.
- Wrap: ADRS_W=4, NSAMPLES=0, CH_EN=01, run 20 samples.
  -> write 17 lands at adrs 0; START during the run is ignored.
- RSTN asserted during SHIFT.
  -> ADCS=1, ADSCLK=0 and ACTIVE=0 asynchronously; no write.

Source files
------------

// File: rtl/adc_acq_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// adc_acq_sequencer_pkg
// Shared definitions for the AD7643 acquisition path. The USB command decoder
// imports the same state encoding and default constants.
//   acq_state_t     : sequencer state encoding
//   DEF_*           : default timing / width constants
// -----------------------------------------------------------------------------
package adc_acq_sequencer_pkg;

  localparam int DEF_CONV_PERIOD = 250;  // clocks between CNVST rises (minimum)
  localparam int DEF_CNVST_W     = 4;    // CNVST high width
  localparam int DEF_BUSY_TMO    = 200;  // CNVST rise to BUSY fall limit
  localparam int DEF_NBITS       = 18;   // ADC word length
  localparam int DEF_OUT_W       = 16;   // stored word width (MSBs of sample)
  localparam int DEF_ADRS_W      = 15;   // waveform memory address width

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAITBUSY,
    S_SHIFT,
    S_WR0,
    S_WR1,
    S_HOLD
  } acq_state_t;

endpackage

// File: rtl/adc_serial_shifter.sv
// -----------------------------------------------------------------------------
// adc_serial_shifter
// Serial-slave readout of two AD7643 SDOUT lines sharing one SCLK / CS.
// A start pulse drops cs_n; sclk then toggles every clock. Each 1->0 sclk
// transition shifts both data lines in MSB-first. After NBITS falling
// transitions cs_n returns high with sclk low and done pulses for one clock.
// Ports:
//   clk, rstn        : clock (logic on falling edge), async active-low reset
//   start            : one-clock request to begin a readout (ignored if busy)
//   sdout0, sdout1   : serial data from ch0 / ch1
//   sclk, cs_n       : shared serial clock and chip select (registered)
//   done             : one-clock pulse, words valid from this cycle on
//   word0, word1     : top OUT_W bits of each captured sample
// -----------------------------------------------------------------------------
module adc_serial_shifter
  import adc_acq_sequencer_pkg::*;
#(
  parameter int NBITS = DEF_NBITS,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             sdout0,
  input  logic             sdout1,
  output logic             sclk,
  output logic             cs_n,
  output logic             done,
  output logic [OUT_W-1:0] word0,
  output logic [OUT_W-1:0] word1
);

  localparam int              FC_W      = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [FC_W-1:0] LAST_FALL = FC_W'(NBITS - 1);

  logic [FC_W-1:0]  fall_cnt;
  logic [NBITS-1:0] sr0;
  logic [NBITS-1:0] sr1;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      done     <= 1'b0;
      fall_cnt <= '0;
      // NOTE: the data registers are reset too; they are small and this keeps
      // the word outputs defined before the first readout.
      sr0      <= '0;
      sr1      <= '0;
    end else begin
      done <= 1'b0;
      if (cs_n) begin
        if (start) begin
          cs_n     <= 1'b0;
          sclk     <= 1'b0;
          fall_cnt <= '0;
        end
      end else if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        // Falling transition: capture the bit the ADC held during the high phase.
        sclk <= 1'b0;
        sr0  <= {sr0[NBITS-2:0], sdout0};
        sr1  <= {sr1[NBITS-2:0], sdout1};
        if (fall_cnt == LAST_FALL) begin
          cs_n <= 1'b1;
          done <= 1'b1;
        end else begin
          fall_cnt <= fall_cnt + FC_W'(1);
        end
      end
    end
  end

  assign word0 = sr0[NBITS-1 -: OUT_W];
  assign word1 = sr1[NBITS-1 -: OUT_W];

endmodule

// File: rtl/adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// adc_acq_sequencer
// Drives one AD7643 pair (ch0/ch1): common conversion, wait for BUSY, shift
// both words out, then write ch0 then ch1 into the waveform memory. Sample
// points are paced by a period counter restarted at every CNVST rise.
// Ports:
//   clk, rstn            : clock (all logic on falling edge), async reset
//   start, stop          : one-clock command pulses
//   nsamples             : sample points per run, 0 = continuous with wrap
//   ch_en                : channel enables, latched at start
//   adcnvst, adcs, adsclk: ADC control (shared by both converters)
//   adsdout0/1, adbusy0/1: ADC serial data and busy inputs
//   mem_we/adrs/data     : waveform memory write port
//   active, done, err    : status (running, normal end pulse, sticky timeout)
//   sample_cnt           : completed sample points
// -----------------------------------------------------------------------------
module adc_acq_sequencer
  import adc_acq_sequencer_pkg::*;
#(
  parameter int CONV_PERIOD = DEF_CONV_PERIOD,
  parameter int CNVST_W     = DEF_CNVST_W,
  parameter int BUSY_TMO    = DEF_BUSY_TMO,
  parameter int NBITS       = DEF_NBITS,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int ADRS_W      = DEF_ADRS_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADRS_W-1:0] nsamples,
  input  logic [1:0]        ch_en,
  output logic              adcnvst,
  output logic              adcs,
  output logic              adsclk,
  input  logic              adsdout0,
  input  logic              adsdout1,
  input  logic              adbusy0,
  input  logic              adbusy1,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [OUT_W-1:0]  mem_data,
  output logic              active,
  output logic              done,
  output logic              err,
  output logic [ADRS_W-1:0] sample_cnt
);

  // Period counter must reach the larger of the two limits; one spare bit
  // lets it saturate without ever wrapping back below a limit.
  localparam int MAX_LIM = (CONV_PERIOD > BUSY_TMO) ? CONV_PERIOD : BUSY_TMO;
  localparam int CNT_W   = $clog2(MAX_LIM + 1) + 1;

  localparam logic [CNT_W-1:0] CNVST_LAST = CNT_W'(CNVST_W - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(BUSY_TMO - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CONV_PERIOD - 1);

  acq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        en_q;
  logic [ADRS_W-1:0] nsamples_q;
  logic [ADRS_W-1:0] adrs_q;
  logic              stop_pend;
  logic [1:0]        seen;
  logic [1:0]        busy_meta;
  logic [1:0]        busy_sync;
  logic              busy_ready;
  logic              shift_start;
  logic              shift_done;
  logic [OUT_W-1:0]  word0;
  logic [OUT_W-1:0]  word1;

  // BUSY comes from the ADC's own timing domain: two-flop synchronizer.
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_meta <= '0;
      busy_sync <= '0;
    end else begin
      busy_meta <= {adbusy1, adbusy0};
      busy_sync <= busy_meta;
    end
  end

  // Every enabled channel has been busy since CNVST and is now idle again.
  assign busy_ready  = &(~en_q | (seen & ~busy_sync));
  assign shift_start = (state == S_WAITBUSY) && busy_ready;

  adc_serial_shifter #(
    .NBITS (NBITS),
    .OUT_W (OUT_W)
  ) u_shifter (
    .clk    (clk),
    .rstn   (rstn),
    .start  (shift_start),
    .sdout0 (adsdout0),
    .sdout1 (adsdout1),
    .sclk   (adsclk),
    .cs_n   (adcs),
    .done   (shift_done),
    .word0  (word0),
    .word1  (word1)
  );

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      en_q       <= '0;
      nsamples_q <= '0;
      adrs_q     <= '0;
      stop_pend  <= 1'b0;
      seen       <= '0;
      adcnvst    <= 1'b0;
      mem_we     <= 1'b0;
      mem_adrs   <= '0;
      mem_data   <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sample_cnt <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;

      if (stop && (state != S_IDLE)) stop_pend <= 1'b1;

      // Counts clocks since the last CNVST rise; restarted on CONV entry below.
      if ((state != S_IDLE) && (cnt != '1)) cnt <= cnt + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (start && (ch_en != 2'b00)) begin
            en_q       <= ch_en;
            nsamples_q <= nsamples;
            err        <= 1'b0;
            sample_cnt <= '0;
            adrs_q     <= '0;
            stop_pend  <= 1'b0;
            active     <= 1'b1;
            state      <= S_CONV;
            cnt        <= '0;
            adcnvst    <= 1'b1;
            seen       <= '0;
          end
        end

        S_CONV: begin
          seen <= seen | busy_sync;
          if (cnt == CNVST_LAST) begin
            adcnvst <= 1'b0;
            state   <= S_WAITBUSY;
          end
        end

        S_WAITBUSY: begin
          seen <= seen | busy_sync;
          if (busy_ready) begin
            state <= S_SHIFT;
          end else if (cnt >= TMO_LAST) begin
            err       <= 1'b1;
            active    <= 1'b0;
            stop_pend <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_SHIFT: begin
          if (shift_done) state <= S_WR0;
        end

        S_WR0: begin
          if (en_q[0]) begin
            mem_we   <= 1'b1;
            mem_adrs <= adrs_q;
            mem_data <= word0;
            adrs_q   <= adrs_q + ADRS_W'(1);
          end
          state <= S_WR1;
        end

        S_WR1: begin
          if (en_q[1]) begin
            mem_we   <= 1'b1;
            mem_adrs <= adrs_q;
            mem_data <= word1;
            adrs_q   <= adrs_q + ADRS_W'(1);
          end
          sample_cnt <= sample_cnt + ADRS_W'(1);
          state      <= S_HOLD;
        end

        S_HOLD: begin
          // ">=" also covers an overrun: a late sequence restarts at once.
          if (cnt >= HOLD_LAST) begin
            if (stop_pend || stop ||
                ((nsamples_q != '0) && (sample_cnt == nsamples_q))) begin
              done      <= 1'b1;
              active    <= 1'b0;
              stop_pend <= 1'b0;
              state     <= S_IDLE;
            end else begin
              state   <= S_CONV;
              cnt     <= '0;
              adcnvst <= 1'b1;
              seen    <= '0;
            end
          end
        end

        default: begin
          active  <= 1'b0;
          adcnvst <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_acq_sequencer
// Directed bench for adc_acq_sequencer with a behavioural AD7643 pair model.
// The DUT runs on the falling clock edge; the bench drives and samples on the
// rising edge. Address width is reduced to 4 bits so wrap is reachable.
// -----------------------------------------------------------------------------
module tb_adc_acq_sequencer;

  localparam int ADRS_W = 4;
  localparam int NBITS  = 18;
  localparam int OUT_W  = 16;

  logic              clk      = 1'b0;
  logic              rstn     = 1'b0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic [ADRS_W-1:0] nsamples = '0;
  logic [1:0]        ch_en    = '0;
  logic              adcnvst;
  logic              adcs;
  logic              adsclk;
  logic              adsdout0;
  logic              adsdout1;
  logic              adbusy0  = 1'b0;
  logic              adbusy1  = 1'b0;
  logic              mem_we;
  logic [ADRS_W-1:0] mem_adrs;
  logic [OUT_W-1:0]  mem_data;
  logic              active;
  logic              done;
  logic              err;
  logic [ADRS_W-1:0] sample_cnt;

  always #5 clk = ~clk;

  adc_acq_sequencer #(.ADRS_W(ADRS_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .nsamples   (nsamples),
    .ch_en      (ch_en),
    .adcnvst    (adcnvst),
    .adcs       (adcs),
    .adsclk     (adsclk),
    .adsdout0   (adsdout0),
    .adsdout1   (adsdout1),
    .adbusy0    (adbusy0),
    .adbusy1    (adbusy1),
    .mem_we     (mem_we),
    .mem_adrs   (mem_adrs),
    .mem_data   (mem_data),
    .active     (active),
    .done       (done),
    .err        (err),
    .sample_cnt (sample_cnt)
  );

  // ---------------- ADC pair model ----------------
  logic [NBITS-1:0] word0  = '0;
  logic [NBITS-1:0] word1  = '0;
  bit               stuck0 = 1'b0;
  int               bit_idx = -1;

  // MSB valid once CS falls; next bit presented shortly after each SCLK fall.
  always @(negedge adcs) bit_idx = NBITS - 1;
  always @(negedge adsclk) #1 bit_idx = bit_idx - 1;
  assign adsdout0 = (bit_idx >= 0 && bit_idx < NBITS) ? word0[bit_idx[4:0]] : 1'b0;
  assign adsdout1 = (bit_idx >= 0 && bit_idx < NBITS) ? word1[bit_idx[4:0]] : 1'b0;

  always begin
    @(posedge adcnvst);
    #25;
    adbusy0 = 1'b1;
    adbusy1 = 1'b1;
    #400;
    if (!stuck0) adbusy0 = 1'b0;
    adbusy1 = 1'b0;
  end

  // ---------------- Observation logs ----------------
  typedef struct packed {
    logic [ADRS_W-1:0] a;
    logic [OUT_W-1:0]  d;
  } wr_t;

  wr_t wr_q[$];
  time cnv_t[$];
  int  done_cnt = 0;
  time done_t   = 0;
  time err_t    = 0;

  always @(posedge clk) begin
    if (mem_we) wr_q.push_back('{a: mem_adrs, d: mem_data});
    if (done) done_cnt++;
  end
  always @(posedge adcnvst) cnv_t.push_back($time);
  always @(posedge done) done_t = $time;
  always @(posedge err) err_t = $time;

  // ---------------- Checking helpers ----------------
  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_logs();
    wr_q.delete();
    cnv_t.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [1:0] en, input int ns, input bit with_stop);
    @(posedge clk);
    ch_en    = en;
    nsamples = ADRS_W'(ns);
    start    = 1'b1;
    stop     = with_stop;
    @(posedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    stop = 1'b1;
    @(posedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    bit seen_done = 1'b0;
    for (int i = 0; i < max_cyc && !seen_done; i++) begin
      @(posedge clk);
      seen_done = done;
    end
    check(name, 32'(seen_done), 32'd1);
  endtask

  task automatic wait_cs_low(input string name, input int max_cyc);
    bit low = 1'b0;
    for (int i = 0; i < max_cyc && !low; i++) begin
      @(posedge clk);
      low = !adcs;
    end
    check(name, 32'(low), 32'd1);
  endtask

  task automatic wait_writes(input string name, input int n, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk);
      got = (wr_q.size() >= n);
    end
    check(name, 32'(got), 32'd1);
  endtask

  // ---------------- Vector table ----------------
  typedef struct {
    logic [1:0]       en;
    int               ns;
    logic [NBITS-1:0] w0;
    logic [NBITS-1:0] w1;
    logic [OUT_W-1:0] d0;
    logic [OUT_W-1:0] d1;
    int               nwr;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{en: 2'b01, ns: 3, w0: 18'h2AAAA, w1: 18'h15555, d0: 16'hAAAA, d1: 16'h5555, nwr: 3};
    vecs[1] = '{en: 2'b11, ns: 2, w0: 18'h3FFFF, w1: 18'h00004, d0: 16'hFFFF, d1: 16'h0001, nwr: 4};
    vecs[2] = '{en: 2'b10, ns: 2, w0: 18'h00000, w1: 18'h12345, d0: 16'h0000, d1: 16'h48D1, nwr: 2};

    // ---- reset state ----
    tick(3);
    check("rst_adcnvst",    32'(adcnvst),    32'd0);
    check("rst_adcs",       32'(adcs),       32'd1);
    check("rst_adsclk",     32'(adsclk),     32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_mem_adrs",   32'(mem_adrs),   32'd0);
    check("rst_mem_data",   32'(mem_data),   32'd0);
    check("rst_active",     32'(active),     32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_err",        32'(err),        32'd0);
    check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    @(posedge clk);
    rstn = 1'b1;
    tick(2);

    // ---- START with no channel enabled is ignored ----
    clear_logs();
    pulse_start(2'b00, 1, 1'b0);
    tick(3);
    check("chen0_active", 32'(active), 32'd0);
    check("chen0_cnvst",  32'(cnv_t.size()), 32'd0);

    // ---- table-driven runs ----
    for (int v = 0; v < 3; v++) begin
      int idx;
      clear_logs();
      word0 = vecs[v].w0;
      word1 = vecs[v].w1;
      pulse_start(vecs[v].en, vecs[v].ns, 1'b0);
      wait_done($sformatf("v%0d_done", v), vecs[v].ns * 260 + 100);
      tick(2);
      check($sformatf("v%0d_nwr", v), 32'(wr_q.size()), 32'(vecs[v].nwr));
      idx = 0;
      for (int s = 0; s < vecs[v].ns; s++) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (vecs[v].en[ch] && idx < wr_q.size()) begin
            check($sformatf("v%0d_w%0d_adrs", v, idx), 32'(wr_q[idx].a), 32'(idx % 16));
            check($sformatf("v%0d_w%0d_data", v, idx), 32'(wr_q[idx].d),
                  32'(ch == 0 ? vecs[v].d0 : vecs[v].d1));
          end
          if (vecs[v].en[ch]) idx++;
        end
      end
      check($sformatf("v%0d_ncnv", v), 32'(cnv_t.size()), 32'(vecs[v].ns));
      for (int i = 1; i < cnv_t.size(); i++)
        check($sformatf("v%0d_period%0d", v, i), 32'(cnv_t[i] - cnv_t[i-1]), 32'd2500);
      check($sformatf("v%0d_sample_cnt", v), 32'(sample_cnt), 32'(vecs[v].ns));
      check($sformatf("v%0d_done_cnt", v),   32'(done_cnt),   32'd1);
      check($sformatf("v%0d_active", v),     32'(active),     32'd0);
      check($sformatf("v%0d_err", v),        32'(err),        32'd0);
    end

    // ---- START and STOP together in IDLE: START wins ----
    clear_logs();
    word0 = 18'h2AAAA;
    pulse_start(2'b01, 2, 1'b1);
    wait_done("ss_done", 700);
    tick(2);
    check("ss_nwr",        32'(wr_q.size()), 32'd2);
    check("ss_sample_cnt", 32'(sample_cnt),  32'd2);

    // ---- BUSY stuck high: timeout ----
    clear_logs();
    stuck0 = 1'b1;
    begin
      bit got_err = 1'b0;
      pulse_start(2'b01, 1, 1'b0);
      for (int i = 0; i < 400 && !got_err; i++) begin
        @(posedge clk);
        got_err = err;
      end
      check("tmo_err", 32'(got_err), 32'd1);
    end
    check("tmo_ncnv", 32'(cnv_t.size()), 32'd1);
    if (cnv_t.size() > 0) check("tmo_delay", 32'(err_t - cnv_t[0]), 32'd2000);
    tick(5);
    check("tmo_active", 32'(active),      32'd0);
    check("tmo_nwr",    32'(wr_q.size()), 32'd0);
    check("tmo_done",   32'(done_cnt),    32'd0);
    stuck0  = 1'b0;
    adbusy0 = 1'b0;
    tick(3);
    clear_logs();
    pulse_start(2'b01, 1, 1'b0);
    check("tmo_err_cleared", 32'(err), 32'd0);
    wait_done("tmo_rerun_done", 400);
    tick(2);
    check("tmo_rerun_nwr", 32'(wr_q.size()), 32'd1);

    // ---- STOP during SHIFT in continuous mode ----
    clear_logs();
    word0 = 18'h2AAAA;
    pulse_start(2'b01, 0, 1'b0);
    wait_cs_low("stop_cs_low", 300);
    tick(3);
    pulse_stop();
    wait_done("stop_done", 400);
    tick(2);
    check("stop_nwr", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) begin
      check("stop_adrs", 32'(wr_q[0].a), 32'd0);
      check("stop_data", 32'(wr_q[0].d), 32'hAAAA);
    end
    check("stop_ncnv", 32'(cnv_t.size()), 32'd1);
    if (cnv_t.size() > 0) check("stop_hold_len", 32'(done_t - cnv_t[0]), 32'd2500);
    check("stop_sample_cnt", 32'(sample_cnt), 32'd1);

    // ---- address wrap in continuous mode, START ignored mid-run ----
    clear_logs();
    word0 = 18'h2AAAA;
    word1 = 18'h00004;
    pulse_start(2'b01, 0, 1'b0);
    wait_writes("wrap_first5", 5, 5 * 260 + 100);
    pulse_start(2'b10, 3, 1'b0);
    wait_writes("wrap_all20", 20, 16 * 260 + 100);
    pulse_stop();
    wait_done("wrap_done", 400);
    tick(2);
    check("wrap_nwr", 32'(wr_q.size()), 32'd20);
    begin
      int bad = 0;
      for (int i = 0; i < wr_q.size(); i++)
        if (wr_q[i].a != ADRS_W'(i % 16) || wr_q[i].d != 16'hAAAA) bad++;
      check("wrap_seq_bad", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 1; i < cnv_t.size(); i++)
        if (cnv_t[i] - cnv_t[i-1] != 2500) bad++;
      check("wrap_period_bad", 32'(bad), 32'd0);
    end
    if (wr_q.size() > 16) check("wrap_w17_adrs", 32'(wr_q[16].a), 32'd0);
    check("wrap_sample_cnt", 32'(sample_cnt), 32'd4);
    check("wrap_mem_adrs",   32'(mem_adrs),   32'd3);

    // ---- reset asserted during SHIFT ----
    clear_logs();
    pulse_start(2'b01, 0, 1'b0);
    wait_cs_low("rst_cs_low", 300);
    tick(4);
    @(posedge clk);
    rstn = 1'b0;
    #1;
    check("rstmid_adcs",     32'(adcs),     32'd1);
    check("rstmid_adsclk",   32'(adsclk),   32'd0);
    check("rstmid_active",   32'(active),   32'd0);
    check("rstmid_mem_adrs", 32'(mem_adrs), 32'd0);
    tick(3);
    rstn = 1'b1;
    tick(5);
    check("rstmid_nwr",    32'(wr_q.size()), 32'd0);
    check("rstmid_active2", 32'(active),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
